// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then shifts one byte
// out on the device-generated clock and samples the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);

  localparam int FILT_W = $clog2(FILTER_LEN + 1);
  localparam int INH_W  = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
  localparam logic [INH_W-1:0]  INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t            state;
  logic              c_meta, c_sync, d_meta, d_sync;
  logic              filt_c, fall;
  logic [FILT_W-1:0] filt_cnt;
  logic [9:0]        frame;
  logic [3:0]        bit_idx;
  logic [INH_W-1:0]  inh_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  // Lines idle high, so the synchronizers and filter reset to 1 to avoid a false fall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c_meta   <= 1'b1;
      c_sync   <= 1'b1;
      d_meta   <= 1'b1;
      d_sync   <= 1'b1;
      filt_c   <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      c_meta <= ps2c_in;
      c_sync <= c_meta;
      d_meta <= ps2d_in;
      d_sync <= d_meta;
      fall   <= 1'b0;
      if (c_sync != filt_c) begin
        if (filt_cnt == FILT_LAST) begin
          filt_c   <= c_sync;
          filt_cnt <= '0;
          fall     <= filt_c;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      ps2c_oe  <= 1'b0;
      ps2d_oe  <= 1'b0;
      done     <= 1'b0;
      ack_ok   <= 1'b0;
      err      <= 1'b0;
      frame    <= '0;
      bit_idx  <= '0;
      inh_cnt  <= '0;
      tmo_cnt  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            frame    <= {1'b1, ~^tx_data, tx_data};
            ack_ok   <= 1'b0;
            bit_idx  <= '0;
            inh_cnt  <= '0;
            ps2c_oe  <= 1'b1;
            ps2d_oe  <= 1'b0;
            busy     <= 1'b1;
            tx_ready <= 1'b0;
            state    <= INHIBIT;
          end
        end
        INHIBIT: begin
          inh_cnt <= inh_cnt + 1'b1;
          if (inh_cnt == INH_LAST) begin
            ps2d_oe <= 1'b1;
            state   <= RTS;
          end
        end
        RTS: begin
          ps2c_oe <= 1'b0;
          tmo_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT, ACK: begin
          // Every device clock fall restarts the inter-edge watchdog.
          if (fall) begin
            tmo_cnt <= '0;
            if (state == SHIFT) begin
              ps2d_oe <= ~frame[bit_idx];
              bit_idx <= bit_idx + 1'b1;
              if (bit_idx == 4'd9) state <= ACK;
            end else begin
              ack_ok <= ~d_sync;
              state  <= WAIT_IDLE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            ps2c_oe  <= 1'b0;
            ps2d_oe  <= 1'b0;
            err      <= 1'b1;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (filt_c && d_sync) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          ps2c_oe  <= 1'b0;
          ps2d_oe  <= 1'b0;
          busy     <= 1'b0;
          tx_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
